// File: rtl/bp_cce_lce_req_arbiter.sv
// bp_cce_lce_req_arbiter: round-robin arbiter feeding one registered LCE request slot to the CCE
module bp_cce_lce_req_arbiter #(
  parameter int num_lce_p = 4,
  parameter int lce_req_width_p = 128,
  localparam int lg_num_lce_lp = $clog2(num_lce_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_lce_p*lce_req_width_p-1:0]   lce_req_i,
  input  logic [num_lce_p-1:0]                   lce_req_v_i,
  output logic [num_lce_p-1:0]                   lce_req_yumi_o,
  output logic [lce_req_width_p-1:0]             cce_req_o,
  output logic                                   cce_req_v_o,
  input  logic                                   cce_req_yumi_i,
  output logic [lg_num_lce_lp-1:0]               cce_req_src_o
);
  logic                       full_r;
  logic [lce_req_width_p-1:0] data_r;
  logic [lg_num_lce_lp-1:0]   src_r, rr_ptr_r, gnt_idx;
  logic                       gnt_v, can_accept, grant;
  // Descending scan so the source closest to the pointer is assigned last and wins.
  always_comb begin
    int j;
    j = 0;
    gnt_v = 1'b0;
    gnt_idx = '0;
    for (int i = num_lce_p - 1; i >= 0; i--) begin
      j = int'(rr_ptr_r) + i;
      if (j >= num_lce_p) j = j - num_lce_p;
      if (lce_req_v_i[j]) begin
        gnt_v = 1'b1;
        gnt_idx = lg_num_lce_lp'(j);
      end
    end
  end
  assign can_accept = ~full_r | cce_req_yumi_i;
  assign grant = can_accept & gnt_v;
  assign lce_req_yumi_o = (grant & ~reset_i) ? (num_lce_p'(1) << gnt_idx) : '0;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_r <= 1'b0;
      data_r <= '0;
      src_r <= '0;
      rr_ptr_r <= '0;
    end else if (grant) begin
      full_r <= 1'b1;
      data_r <= lce_req_i[gnt_idx*lce_req_width_p +: lce_req_width_p];
      src_r <= gnt_idx;
      rr_ptr_r <= (gnt_idx == lg_num_lce_lp'(num_lce_p - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (cce_req_yumi_i) begin
      full_r <= 1'b0;
    end
  end
  assign cce_req_o = data_r;
  assign cce_req_v_o = full_r;
  assign cce_req_src_o = src_r;
  yumi_only_when_full: assert property (@(posedge clk_i) disable iff (reset_i) cce_req_yumi_i |-> full_r);
endmodule
